// File: rtl/spi_apb_sched.sv
// Round-robin scheduler sharing one spi_ctrl APB port among NUM_REQ requesters.
// Each grant runs: read slot index, load addr/data slots, start, poll, optional read-back.
module spi_apb_sched #(
  parameter int         NUM_REQ    = 4,
  parameter int         POLL_GAP   = 8,
  parameter int         POLL_LIMIT = 255,
  parameter logic [7:0] RDATA_ADDR = 8'h30
) (
  input  logic                 pclk_i,
  input  logic                 prst_i,
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [8*NUM_REQ-1:0] req_addr_i,
  input  logic [8*NUM_REQ-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]   gnt_o,
  output logic [NUM_REQ-1:0]   done_o,
  output logic                 err_o,
  output logic [7:0]           rdata_o,
  output logic                 busy_o,
  output logic [7:0]           paddr_o,
  output logic [7:0]           pwdata_o,
  output logic                 pwrite_o,
  output logic                 penable_o,
  input  logic [7:0]           prdata_i,
  input  logic                 pready_i
);

  // state    | meaning
  // IDLE     | waiting for any request
  // GRANT    | gnt_o pulse, request latched
  // RD_IDX   | APB read of 8'h20, slot index from bits [6:4]
  // WR_ADDR  | APB write addr byte to 8'h00+idx
  // WR_DATA  | APB write data byte to 8'h10+idx
  // WR_CTRL  | APB write 8'h01 to 8'h20 (start)
  // GAP      | POLL_GAP idle cycles
  // POLL     | APB read of 8'h20, bit0 = still busy
  // RD_DATA  | APB read of RDATA_ADDR (read requests only)
  // DONE     | done_o / err_o pulse
  typedef enum logic [3:0] {
    S_IDLE, S_GRANT, S_RD_IDX, S_WR_ADDR, S_WR_DATA,
    S_WR_CTRL, S_GAP, S_POLL, S_RD_DATA, S_DONE
  } state_t;

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(POLL_LIMIT + 1);
  localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);
  localparam logic [CW-1:0] POLL_MAX = CW'(POLL_LIMIT);

  state_t        state_q, state_n;
  logic          access_q, access_n;
  logic [PW-1:0] ptr_q, ptr_n;
  logic [PW-1:0] sel_q, sel_n;
  logic [7:0]    addr_q, addr_n;
  logic [7:0]    wdata_q, wdata_n;
  logic [2:0]    idx_q, idx_n;
  logic [GW-1:0] gap_q, gap_n;
  logic [CW-1:0] poll_q, poll_n;
  logic          err_q, err_n;
  logic [7:0]    rdata_q, rdata_n;

  logic          arb_hit;
  logic [PW-1:0] arb_sel;
  logic [PW:0]   cand;
  logic [7:0]    addr_pick, wdata_pick;
  logic          is_xfer, xfer_done;
  logic [CW-1:0] poll_inc;
  logic          unused_prdata;

  assign unused_prdata = ^{prdata_i[7], prdata_i[3:1]};

  // First pending request at or after the pointer, wrapping.
  always_comb begin
    arb_hit = 1'b0;
    arb_sel = '0;
    cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr_q} + (PW+1)'(i);
      if (cand >= (PW+1)'(NUM_REQ)) cand = cand - (PW+1)'(NUM_REQ);
      if (!arb_hit && req_i[cand[PW-1:0]]) begin
        arb_hit = 1'b1;
        arb_sel = cand[PW-1:0];
      end
    end
  end

  always_comb begin
    addr_pick  = '0;
    wdata_pick = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_sel == PW'(i)) begin
        addr_pick  = req_addr_i[8*i +: 8];
        wdata_pick = req_wdata_i[8*i +: 8];
      end
    end
  end

  always_ff @(posedge pclk_i or posedge prst_i) begin
    if (prst_i) begin
      state_q  <= S_IDLE;
      access_q <= 1'b0;
      ptr_q    <= '0;
      sel_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      idx_q    <= '0;
      gap_q    <= '0;
      poll_q   <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_n;
      access_q <= access_n;
      ptr_q    <= ptr_n;
      sel_q    <= sel_n;
      addr_q   <= addr_n;
      wdata_q  <= wdata_n;
      idx_q    <= idx_n;
      gap_q    <= gap_n;
      poll_q   <= poll_n;
      err_q    <= err_n;
      rdata_q  <= rdata_n;
    end
  end

  always_comb begin
    is_xfer = (state_q == S_RD_IDX) || (state_q == S_WR_ADDR) || (state_q == S_WR_DATA) ||
              (state_q == S_WR_CTRL) || (state_q == S_POLL) || (state_q == S_RD_DATA);
    xfer_done = is_xfer && access_q && pready_i;
    poll_inc  = poll_q + 1'b1;

    state_n  = state_q;
    access_n = access_q;
    ptr_n    = ptr_q;
    sel_n    = sel_q;
    addr_n   = addr_q;
    wdata_n  = wdata_q;
    idx_n    = idx_q;
    gap_n    = gap_q;
    poll_n   = poll_q;
    err_n    = err_q;
    rdata_n  = rdata_q;

    // SETUP is always one cycle; ACCESS lasts until pready_i.
    if (is_xfer) access_n = access_q ? !pready_i : 1'b1;

    case (state_q)
      S_IDLE: begin
        if (arb_hit) begin
          state_n = S_GRANT;
          sel_n   = arb_sel;
          ptr_n   = (arb_sel == PW'(NUM_REQ - 1)) ? '0 : arb_sel + 1'b1;
          addr_n  = addr_pick;
          wdata_n = wdata_pick;
          err_n   = 1'b0;
        end
      end
      S_GRANT: begin
        state_n  = S_RD_IDX;
        access_n = 1'b0;
      end
      S_RD_IDX: begin
        if (xfer_done) begin
          idx_n   = prdata_i[6:4];
          state_n = S_WR_ADDR;
        end
      end
      S_WR_ADDR: if (xfer_done) state_n = S_WR_DATA;
      S_WR_DATA: if (xfer_done) state_n = S_WR_CTRL;
      S_WR_CTRL: begin
        if (xfer_done) begin
          gap_n   = GAP_LOAD;
          state_n = (POLL_GAP > 0) ? S_GAP : S_POLL;
        end
      end
      S_GAP: begin
        if (gap_q == '0) state_n = S_POLL;
        else             gap_n   = gap_q - 1'b1;
      end
      S_POLL: begin
        if (xfer_done) begin
          poll_n = poll_inc;
          if (!prdata_i[0]) begin
            state_n = addr_q[7] ? S_DONE : S_RD_DATA;
          end else if (poll_inc == POLL_MAX) begin
            err_n   = 1'b1;
            state_n = S_DONE;
          end else begin
            gap_n   = GAP_LOAD;
            state_n = (POLL_GAP > 0) ? S_GAP : S_POLL;
          end
        end
      end
      S_RD_DATA: begin
        if (xfer_done) begin
          rdata_n = prdata_i;
          state_n = S_DONE;
        end
      end
      S_DONE: begin
        poll_n  = '0;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    gnt_o     = (state_q == S_GRANT) ? (NUM_REQ'(1) << sel_q) : '0;
    done_o    = (state_q == S_DONE)  ? (NUM_REQ'(1) << sel_q) : '0;
    err_o     = (state_q == S_DONE) && err_q;
    busy_o    = (state_q != S_IDLE);
    rdata_o   = rdata_q;
    penable_o = is_xfer && access_q;
    paddr_o   = '0;
    pwdata_o  = '0;
    pwrite_o  = 1'b0;
    case (state_q)
      S_RD_IDX:  paddr_o = 8'h20;
      S_WR_ADDR: begin paddr_o = {5'b0, idx_q};         pwdata_o = addr_q;  pwrite_o = 1'b1; end
      S_WR_DATA: begin paddr_o = 8'h10 | {5'b0, idx_q}; pwdata_o = wdata_q; pwrite_o = 1'b1; end
      S_WR_CTRL: begin paddr_o = 8'h20;                 pwdata_o = 8'h01;   pwrite_o = 1'b1; end
      S_POLL:    paddr_o = 8'h20;
      S_RD_DATA: paddr_o = RDATA_ADDR;
      default:   paddr_o = '0;
    endcase
  end

endmodule

// File: tb/tb_spi_apb_sched.sv
// Directed bench for spi_apb_sched with a small spi_ctrl APB slave model.
module tb_spi_apb_sched;

  localparam int NR = 4;

  logic          pclk_i = 1'b0;
  logic          prst_i;
  logic [NR-1:0] req_i;
  logic [8*NR-1:0] req_addr_i, req_wdata_i;
  logic [NR-1:0] gnt_o, done_o;
  logic          err_o, busy_o, pwrite_o, penable_o, pready_i;
  logic [7:0]    rdata_o, paddr_o, pwdata_o, prdata_i;

  int n_cmp = 0;
  int n_bad = 0;

  // slave model knobs
  logic [2:0] slot_idx;
  int         clear_on;
  logic [7:0] rdata_val;
  logic [7:0] delay_addr;
  int         delay_cyc;
  int         wait_cnt;
  int         poll_num;
  bit         started;
  bit         st_bit;
  logic [7:0] log_addr[$];
  logic [7:0] log_wdata[$];
  bit         log_wr[$];

  spi_apb_sched #(.NUM_REQ(NR), .POLL_GAP(8), .POLL_LIMIT(3), .RDATA_ADDR(8'h30)) dut (
    .pclk_i(pclk_i), .prst_i(prst_i), .req_i(req_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o),
    .rdata_o(rdata_o), .busy_o(busy_o), .paddr_o(paddr_o), .pwdata_o(pwdata_o),
    .pwrite_o(pwrite_o), .penable_o(penable_o), .prdata_i(prdata_i), .pready_i(pready_i)
  );

  always #5 pclk_i = ~pclk_i;

  // Status bit0 reads busy after a start until poll number clear_on (0 = never clears).
  always @(negedge pclk_i) begin
    if (prst_i) begin
      pready_i = 1'b0; prdata_i = 8'h00; wait_cnt = 0;
    end else begin
      if (gnt_o != '0) begin started = 0; poll_num = 0; end
      if (penable_o) begin
        if (paddr_o == delay_addr && wait_cnt < delay_cyc) begin
          pready_i = 1'b0; prdata_i = 8'h00; wait_cnt++;
        end else begin
          wait_cnt = 0; pready_i = 1'b1; prdata_i = 8'h00;
          if (pwrite_o) begin
            if (paddr_o == 8'h20 && pwdata_o == 8'h01) begin started = 1; poll_num = 0; end
          end else if (paddr_o == 8'h20) begin
            st_bit = 0;
            if (started) begin
              poll_num++;
              st_bit = (clear_on == 0) || (poll_num < clear_on);
              if (!st_bit) started = 0;
            end
            prdata_i = {1'b0, slot_idx, 3'b000, st_bit};
          end else if (paddr_o == 8'h30) begin
            prdata_i = rdata_val;
          end
          log_addr.push_back(paddr_o);
          log_wdata.push_back(pwdata_o);
          log_wr.push_back(pwrite_o);
        end
      end else begin
        pready_i = 1'b0; prdata_i = 8'h00; wait_cnt = 0;
      end
    end
  end

  task automatic clear_log;
    log_addr.delete(); log_wdata.delete(); log_wr.delete();
  endtask

  // Runs one request; returns what was observed (no checking here).
  task automatic drive_one(input int k, input logic [7:0] a, input logic [7:0] d,
                           output logic [NR-1:0] g_seen, output logic [NR-1:0] d_seen,
                           output int lat, output logic e_seen, output logic [7:0] r_seen,
                           output bit ok);
    int g_at;
    g_seen = '0; d_seen = '0; lat = -1; e_seen = 1'b0; r_seen = 8'h00; ok = 0; g_at = 0;
    @(negedge pclk_i);
    req_addr_i[8*k +: 8] = a;
    req_wdata_i[8*k +: 8] = d;
    req_i[k] = 1'b1;
    for (int n = 0; n < 400; n++) begin
      @(negedge pclk_i);
      if (gnt_o != '0 && g_seen == '0) begin g_seen = gnt_o; g_at = n; req_i[k] = 1'b0; end
      if (done_o != '0) begin
        d_seen = done_o; lat = n - g_at; e_seen = err_o; r_seen = rdata_o; ok = 1;
        break;
      end
    end
    req_i[k] = 1'b0;
  endtask

  task automatic count_reads(input logic [7:0] a, output int cnt);
    cnt = 0;
    foreach (log_addr[i]) if (!log_wr[i] && log_addr[i] == a) cnt++;
  endtask

  task automatic test_reset;
    bit found;
    prst_i = 1'b1;
    repeat (3) @(negedge pclk_i);
    n_cmp++; if (gnt_o !== '0)     begin n_bad++; $display("FAIL rst_gnt got %h want 0", gnt_o); end
    n_cmp++; if (done_o !== '0)    begin n_bad++; $display("FAIL rst_done got %h want 0", done_o); end
    n_cmp++; if (err_o !== 1'b0)   begin n_bad++; $display("FAIL rst_err got %b want 0", err_o); end
    n_cmp++; if (busy_o !== 1'b0)  begin n_bad++; $display("FAIL rst_busy got %b want 0", busy_o); end
    n_cmp++; if (rdata_o !== 8'h0) begin n_bad++; $display("FAIL rst_rdata got %h want 00", rdata_o); end
    n_cmp++; if ({paddr_o, pwdata_o, pwrite_o, penable_o} !== 18'h0)
      begin n_bad++; $display("FAIL rst_apb got %h/%h/%b/%b want 0", paddr_o, pwdata_o, pwrite_o, penable_o); end
    prst_i = 1'b0;
    slot_idx = 3'd0; clear_on = 1; delay_addr = 8'h00; delay_cyc = 4;
    req_addr_i[7:0] = 8'h80; req_wdata_i[7:0] = 8'h11; req_i = 4'b0001;
    found = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge pclk_i);
      if (gnt_o != '0) req_i = '0;
      if (penable_o && pwrite_o && paddr_o == 8'h00) begin found = 1; break; end
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL rst_reach_wr_addr_access got none want seen"); end
    #2 prst_i = 1'b1;
    #1;
    n_cmp++; if (penable_o !== 1'b0) begin n_bad++; $display("FAIL rst_mid_penable got %b want 0", penable_o); end
    n_cmp++; if (busy_o !== 1'b0)    begin n_bad++; $display("FAIL rst_mid_busy got %b want 0", busy_o); end
    n_cmp++; if (gnt_o !== '0)       begin n_bad++; $display("FAIL rst_mid_gnt got %h want 0", gnt_o); end
    @(negedge pclk_i);
    n_cmp++; if (done_o !== '0)      begin n_bad++; $display("FAIL rst_mid_done got %h want 0", done_o); end
    prst_i = 1'b0; delay_addr = 8'hFF; delay_cyc = 0;
    req_i = 4'b0001;
    @(negedge pclk_i);
    n_cmp++; if (gnt_o !== 4'b0001) begin n_bad++; $display("FAIL rst_after_gnt got %b want 0001", gnt_o); end
    req_i = '0;
    found = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge pclk_i);
      if (done_o != '0) begin found = 1; break; end
    end
    n_cmp++; if (!found || done_o !== 4'b0001)
      begin n_bad++; $display("FAIL rst_after_done got %b want 0001", done_o); end
  endtask

  task automatic test_write_slot;
    logic [NR-1:0] g, d; int lat; logic e; logic [7:0] r; bit ok;
    slot_idx = 3'd5; clear_on = 1; clear_log();
    drive_one(2, 8'h85, 8'h3C, g, d, lat, e, r, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL wr_timeout got no done want done"); end
    n_cmp++; if (g !== 4'b0100) begin n_bad++; $display("FAIL wr_gnt got %b want 0100", g); end
    n_cmp++; if (d !== 4'b0100) begin n_bad++; $display("FAIL wr_done got %b want 0100", d); end
    n_cmp++; if (lat != 19) begin n_bad++; $display("FAIL wr_latency got %0d want 19", lat); end
    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL wr_err got %b want 0", e); end
    n_cmp++; if (r !== 8'h00) begin n_bad++; $display("FAIL wr_rdata_hold got %h want 00", r); end
    n_cmp++; if (log_addr.size() != 5) begin n_bad++; $display("FAIL wr_nxfer got %0d want 5", log_addr.size()); end
    n_cmp++; if (log_addr[0] !== 8'h20 || log_wr[0] != 0)
      begin n_bad++; $display("FAIL wr_rd_idx got %h/%0d want 20/read", log_addr[0], log_wr[0]); end
    n_cmp++; if (log_addr[1] !== 8'h05 || log_wdata[1] !== 8'h85 || log_wr[1] != 1)
      begin n_bad++; $display("FAIL wr_addr_slot got %h<-%h want 05<-85", log_addr[1], log_wdata[1]); end
    n_cmp++; if (log_addr[2] !== 8'h15 || log_wdata[2] !== 8'h3C || log_wr[2] != 1)
      begin n_bad++; $display("FAIL wr_data_slot got %h<-%h want 15<-3C", log_addr[2], log_wdata[2]); end
    n_cmp++; if (log_addr[3] !== 8'h20 || log_wdata[3] !== 8'h01 || log_wr[3] != 1)
      begin n_bad++; $display("FAIL wr_ctrl got %h<-%h want 20<-01", log_addr[3], log_wdata[3]); end
  endtask

  task automatic test_read;
    logic [NR-1:0] g, d; int lat, np; logic e; logic [7:0] r; bit ok;
    slot_idx = 3'd2; clear_on = 3; rdata_val = 8'hA7; clear_log();
    drive_one(1, 8'h12, 8'h5A, g, d, lat, e, r, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rd_timeout got no done want done"); end
    n_cmp++; if (d !== 4'b0010) begin n_bad++; $display("FAIL rd_done got %b want 0010", d); end
    n_cmp++; if (lat != 41) begin n_bad++; $display("FAIL rd_latency got %0d want 41", lat); end
    n_cmp++; if (r !== 8'hA7) begin n_bad++; $display("FAIL rd_rdata got %h want A7", r); end
    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL rd_err got %b want 0", e); end
    count_reads(8'h20, np);
    n_cmp++; if (np != 4) begin n_bad++; $display("FAIL rd_polls got %0d status reads want 4", np); end
    n_cmp++; if (log_addr[2] !== 8'h12 || log_wdata[2] !== 8'h5A)
      begin n_bad++; $display("FAIL rd_data_slot got %h<-%h want 12<-5A", log_addr[2], log_wdata[2]); end
    n_cmp++; if (log_addr[log_addr.size()-1] !== 8'h30 || log_wr[log_wr.size()-1] != 0)
      begin n_bad++; $display("FAIL rd_last_xfer got %h want read 30", log_addr[log_addr.size()-1]); end
  endtask

  task automatic test_timeout;
    logic [NR-1:0] g, d; int lat, np, nr; logic e; logic [7:0] r; bit ok;
    slot_idx = 3'd1; clear_on = 0; rdata_val = 8'h5B; clear_log();
    drive_one(3, 8'h22, 8'h00, g, d, lat, e, r, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL to_timeout got no done want done"); end
    n_cmp++; if (d !== 4'b1000) begin n_bad++; $display("FAIL to_done got %b want 1000", d); end
    n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL to_err got %b want 1", e); end
    n_cmp++; if (lat != 39) begin n_bad++; $display("FAIL to_latency got %0d want 39", lat); end
    n_cmp++; if (r !== 8'hA7) begin n_bad++; $display("FAIL to_rdata_hold got %h want A7", r); end
    count_reads(8'h20, np);
    count_reads(8'h30, nr);
    n_cmp++; if (np != 4) begin n_bad++; $display("FAIL to_polls got %0d status reads want 4", np); end
    n_cmp++; if (nr != 0) begin n_bad++; $display("FAIL to_rd_data got %0d reads want 0", nr); end
    @(negedge pclk_i);
    n_cmp++; if (err_o !== 1'b0 || busy_o !== 1'b0)
      begin n_bad++; $display("FAIL to_after got err=%b busy=%b want 0/0", err_o, busy_o); end
  endtask

  task automatic test_pready_stall;
    int n_acc, g_at, lat; bit ok;
    slot_idx = 3'd6; clear_on = 1; delay_addr = 8'h16; delay_cyc = 5; clear_log();
    n_acc = 0; g_at = 0; lat = -1; ok = 0;
    @(negedge pclk_i);
    req_addr_i[7:0] = 8'h81; req_wdata_i[7:0] = 8'hC3; req_i[0] = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge pclk_i);
      if (gnt_o != '0) begin g_at = n; req_i[0] = 1'b0; end
      if (paddr_o == 8'h16 && busy_o) begin
        if (penable_o) n_acc++;
        n_cmp++; if (pwdata_o !== 8'hC3 || pwrite_o !== 1'b1)
          begin n_bad++; $display("FAIL stall_hold got %h/%b want C3/1", pwdata_o, pwrite_o); end
      end
      if (done_o != '0) begin lat = n - g_at; ok = 1; break; end
    end
    delay_addr = 8'hFF; delay_cyc = 0;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL stall_timeout got no done want done"); end
    n_cmp++; if (n_acc != 6) begin n_bad++; $display("FAIL stall_access_cycles got %0d want 6", n_acc); end
    n_cmp++; if (lat != 24) begin n_bad++; $display("FAIL stall_latency got %0d want 24", lat); end
  endtask

  task automatic test_back_to_back;
    int exp_ord[5] = '{0, 1, 2, 3, 0};
    int gt[5];
    int ng, nd;
    ng = 0; nd = 0;
    @(negedge pclk_i);
    prst_i = 1'b1;
    @(negedge pclk_i);
    prst_i = 1'b0;
    slot_idx = 3'd3; clear_on = 1;
    for (int k = 0; k < NR; k++) begin
      req_addr_i[8*k +: 8] = 8'h80 | 8'(k);
      req_wdata_i[8*k +: 8] = 8'h40 + 8'(k);
    end
    req_i = 4'b1111;
    for (int n = 0; n < 300; n++) begin
      @(negedge pclk_i);
      if (gnt_o != '0) begin
        if (ng < 5) begin
          n_cmp++; if (gnt_o !== 4'(1 << exp_ord[ng]))
            begin n_bad++; $display("FAIL b2b_gnt%0d got %b want %b", ng, gnt_o, 4'(1 << exp_ord[ng])); end
          gt[ng] = n; ng++;
          if (ng == 5) req_i = '0;
        end else begin
          n_cmp++; n_bad++; $display("FAIL b2b_extra_gnt got %b want none", gnt_o);
        end
      end
      if (done_o != '0 && nd < ng) begin
        n_cmp++; if (done_o !== 4'(1 << exp_ord[nd]))
          begin n_bad++; $display("FAIL b2b_done%0d got %b want %b", nd, done_o, 4'(1 << exp_ord[nd])); end
        n_cmp++; if (n - gt[nd] != 19)
          begin n_bad++; $display("FAIL b2b_lat%0d got %0d want 19", nd, n - gt[nd]); end
        nd++;
        if (nd == 5) break;
      end
    end
    req_i = '0;
    n_cmp++; if (nd != 5) begin n_bad++; $display("FAIL b2b_count got %0d dones want 5", nd); end
  endtask

  initial begin
    prst_i = 1'b1;
    req_i = '0; req_addr_i = '0; req_wdata_i = '0;
    slot_idx = 3'd0; clear_on = 1; rdata_val = 8'h00; delay_addr = 8'hFF; delay_cyc = 0;
    test_reset();
    test_write_slot();
    test_read();
    test_timeout();
    test_pready_stall();
    test_back_to_back();
    repeat (2) @(negedge pclk_i);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
